decimal_entry: RTL
==================

# decimal_entry

Front-panel input block: the opposite direction of the seven-segment binary-to-decimal display path. Four debounced pushbuttons edit a 4-digit BCD value (thousands..ones). On commit, the block converts the digits to a 13-bit binary number with a sequential multiply-accumulate, saturating at 8191. It then presents the number over a valid/ready handshake to the consumer, e.g. processor I/O or the display's `num` input. Live digits and the cursor position are exported so the display can echo the entry.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable synchronized samples required to accept a button level change (10 ms at 100 MHz); minimum 2.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_next`  in  1  raw button: move cursor one digit right, ones wrapping to thousands.
- `btn_inc`  in  1  raw button: increment the selected digit.
- `btn_dec`  in  1  raw button: decrement the selected digit.
- `btn_load`  in  1  raw button: commit the entry for conversion.
- `digits`  out  16  live BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
- `sel_digit`  out  2  cursor position: 3 = thousands ... 0 = ones.
- `busy`  out  1  high in CONVERT and HOLD.
- `num`  out  13  converted binary value.
- `num_valid`  out  1  `num` and `overflow` are valid.
- `num_ready`  in  1  consumer accepts `num` when `num_valid` and `num_ready` are both high.
- `overflow`  out  1  the entry exceeded 8191 and `num` was saturated.

## Operation
- **Button conditioning**
  - Each button goes through its own 2-flop synchronizer, then a debouncer.
  - The debouncer counter clears whenever the synchronized level equals the stable level. Otherwise it increments.
  - When the counter reaches `DEBOUNCE_CYCLES`-1 while still differing, the stable level flips and the counter clears.
  - A rising edge of the stable level produces a registered 1-cycle press pulse. Releases produce no pulse.
  - Counter width is $clog2(`DEBOUNCE_CYCLES`).
- **IDLE state (editing)**
  - next pulse: `sel_digit` decrements mod 4 (3→2→1→0→3).
  - inc pulse: selected digit becomes +1, with 9 wrapping to 0.
  - dec pulse: selected digit becomes −1, with 0 wrapping to 9.
  - inc and dec pulses in the same cycle: no digit change.
  - next in the same cycle as inc/dec: the edit applies to the old position, and the cursor moves in the same cycle.
  - load pulse: enter CONVERT, clear the 14-bit accumulator and step counter. A load pulse takes priority over any edit pulse in the same cycle; that edit is dropped.
- **CONVERT state**
  - Runs 4 cycles, steps 0..3.
  - Each step: acc ← acc·10 + digit[3−step], where acc·10 = (acc<<3)+(acc<<1) in 14 bits. Step 0 uses thousands.
  - After step 3, go to HOLD.
  - On HOLD entry, register `num` = acc>8191 ? 8191 : acc[12:0] and `overflow` = (acc>8191).
- **HOLD state**
  - `num_valid` is high. `num` and `overflow` are stable while `num_valid` is high.
  - When `num_valid`&`num_ready` is sampled high on an edge, return to IDLE and drop `num_valid` on that edge.
- **Button handling outside IDLE**
  - All press pulses are ignored in CONVERT and HOLD; `digits` is frozen.
  - Debouncers keep running, so a button held through HOLD does not re-pulse on return to IDLE.
- **Persistence**
  - `digits` persist after a conversion.
  - `num` and `overflow` hold their last value until the next conversion.

## Timing
- **Reset values**
  - `digits`=16'h0000, `sel_digit`=3, `busy`=0, `num`=0, `num_valid`=0, `overflow`=0.
  - All debouncer stable levels and counters are 0. FSM is IDLE.
- **Reset mid-operation:** asserting `rst_n` in any state, including CONVERT or HOLD, returns immediately to the reset values. No partial result is ever presented.
- **Press latency:** a raw level held steady is pulsed within `DEBOUNCE_CYCLES`+4 cycles of its first sampling edge. The edited digit or cursor is visible 1 cycle after the pulse.
- **Conversion latency:** with the load pulse high in cycle T, the FSM is CONVERT in T+1..T+4 and `num_valid` is high from T+5.
- **Busy:** `busy` rises in T+1 and falls with `num_valid`.
- **Throughput:** with `num_ready` tied high, `num_valid` is high for exactly 1 cycle.

## Test plan
- `DEBOUNCE_CYCLES`=4: raw `btn_inc` glitches high for 3 cycles, then low → no digit change. Held high 10 cycles → ones... wait, with `sel_digit`=3, thousands becomes 1, with exactly one increment.
- Reset, then enter 1-2-3-4 via inc and next; load with `num_ready`=1 → `num_valid` high at T+5 for 1 cycle, `num`=1234, `overflow`=0, `digits`=16'h1234 retained.
- Enter 9999 and load → `num`=8191, `overflow`=1. Enter 8191 → `num`=8191, `overflow`=0. Enter 8192 → `num`=8191, `overflow`=1.
- Hold `num_ready`=0 for 20 cycles after `num_valid` → `num_valid` and `num` stay stable, inc presses ignored. Raise `num_ready` → `num_valid` drops on that edge, editing resumes.
- Wrap cases: dec on ones=0 → 9; inc on 9 → 0; next from `sel_digit`=0 → 3; inc and dec pulsed in the same cycle → unchanged.
- Assert `rst_n` low during CONVERT step 2 → all outputs at reset values asynchronously. `num_valid` never rises, and the next load of 0000 yields `num`=0.

Source files
------------

// File: rtl/decimal_entry.sv
// Front-panel BCD entry: 4 debounced buttons edit 4 digits; load converts to saturated 13-bit binary.
// Latency: press pulse <= DEBOUNCE_CYCLES+4 cycles; num_valid 5 cycles after load pulse; held until num_ready.
module decimal_entry #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_next,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic        btn_load,
  output logic [15:0] digits,
  output logic [1:0]  sel_digit,
  output logic        busy,
  output logic [12:0] num,
  output logic        num_valid,
  input  logic        num_ready,
  output logic        overflow
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_HOLD} state_t;

  // Bit order for all per-button vectors: 0=next, 1=inc, 2=dec, 3=load
  logic [3:0]         w_raw;
  logic [3:0]         r_sync1;
  logic [3:0]         r_sync2;
  logic [3:0]         r_stable;
  logic [3:0][CW-1:0] r_cnt;
  logic [3:0]         r_pulse;

  assign w_raw = {btn_load, btn_dec, btn_inc, btn_next};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
      r_pulse  <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_pulse <= '0;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
          r_pulse[i]  <= r_sync2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  state_t      r_state;
  logic [15:0] r_digits;
  logic [1:0]  r_sel;
  logic [1:0]  r_step;
  logic [13:0] r_acc;
  logic [12:0] r_num;
  logic        r_num_vld;
  logic        r_ovf;
  logic        r_busy;

  logic [3:0]  w_cur;
  logic [3:0]  w_inc_val;
  logic [3:0]  w_dec_val;
  logic [3:0]  w_conv_dig;
  logic [13:0] w_acc_next;
  logic        w_sat;

  assign w_cur      = r_digits[{r_sel, 2'b00} +: 4];
  assign w_inc_val  = (w_cur == 4'd9) ? 4'd0 : w_cur + 4'd1;
  assign w_dec_val  = (w_cur == 4'd0) ? 4'd9 : w_cur - 4'd1;
  // Step 0 reads thousands: digit index 3-step is the bitwise inverse of a 2-bit step
  assign w_conv_dig = r_digits[{~r_step, 2'b00} +: 4];
  assign w_acc_next = (r_acc << 3) + (r_acc << 1) + {10'd0, w_conv_dig};
  assign w_sat      = (w_acc_next > 14'd8191);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_digits  <= '0;
      r_sel     <= 2'd3;
      r_step    <= '0;
      r_acc     <= '0;
      r_num     <= '0;
      r_num_vld <= 1'b0;
      r_ovf     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_pulse[3]) begin
            r_state <= S_CONVERT;
            r_acc   <= '0;
            r_step  <= '0;
            r_busy  <= 1'b1;
          end else begin
            if (r_pulse[1] && !r_pulse[2]) begin
              r_digits[{r_sel, 2'b00} +: 4] <= w_inc_val;
            end else if (r_pulse[2] && !r_pulse[1]) begin
              r_digits[{r_sel, 2'b00} +: 4] <= w_dec_val;
            end
            if (r_pulse[0]) begin
              r_sel <= r_sel - 2'd1;
            end
          end
        end
        S_CONVERT: begin
          r_acc  <= w_acc_next;
          r_step <= r_step + 2'd1;
          if (r_step == 2'd3) begin
            r_state   <= S_HOLD;
            r_num     <= w_sat ? 13'h1FFF : w_acc_next[12:0];
            r_ovf     <= w_sat;
            r_num_vld <= 1'b1;
          end
        end
        S_HOLD: begin
          if (num_ready) begin
            r_state   <= S_IDLE;
            r_num_vld <= 1'b0;
            r_busy    <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign digits    = r_digits;
  assign sel_digit = r_sel;
  assign busy      = r_busy;
  assign num       = r_num;
  assign num_valid = r_num_vld;
  assign overflow  = r_ovf;

endmodule
